lane_demux_n: RTL
=================

Name: lane_demux_n

Overview:
- Parametrised byte-to-word lane demultiplexer for the symbol-level data path.
- Takes one 8-bit symbol per clock, with a K (control) flag and a valid qualifier.
- Stripes symbols into NUM_LANES byte lanes and emits one wide word every NUM_LANES accepted symbols.
- Realigns on COM, strips SKP, and classifies the lane-0 symbol of each emitted word.
- Sits between the symbol receiver and the packet-framing logic; successor to the fixed-width single-clock demux.

Parameters:
- NUM_LANES, 4, output lane count; legal 2..8.
- ALIGN_ON_COM, 1, 1 = a K-COM forces lane 0; 0 = COM is treated as an ordinary symbol.
- CNT_W, 8, width of the saturating error/realign counters.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  8  incoming symbol.
- k_in  input  1  1 = data_in is a control (K) symbol.
- valid_in  input  1  data_in/k_in qualifier.
- data_out  output  8*NUM_LANES  assembled word; lane i occupies bits [8i+7:8i].
- k_out  output  NUM_LANES  per-lane K flags of data_out.
- valid_out  output  1  one-cycle pulse per assembled word.
- lane0_sym  output  3  class of lane-0 symbol: 0 DATA, 1 COM, 2 STP, 3 SDP, 4 END, 5 IDL, 7 UNKNOWN_K.
- align_evt  output  1  one-cycle pulse when a COM realigns and discards a partial word.
- realign_cnt  output  CNT_W  saturating count of align_evt pulses.
- sym_err  output  1  unknown-K flag (see Optional Feature).
- err_cnt  output  CNT_W  saturating count of sym_err pulses.

Behaviour:
- Reset (async, active-high):
  - data_out, k_out, valid_out, lane0_sym, align_evt, sym_err, realign_cnt, err_cnt = 0.
  - lane_idx = 0; assembly buffer cleared.
- Symbol codes (K symbols only):
  - COM 8'hBC, SKP 8'h1C, STP 8'hFB, SDP 8'h5C, END 8'hFD, IDL 8'h7C.
- Cycle types, decided at each clk edge with valid_in = 1:
  - SKP (k_in = 1, data_in = SKP): dropped. No buffer write; lane_idx unchanged.
  - COM realign (ALIGN_ON_COM = 1, k_in = 1, data_in = COM, lane_idx != 0): partial buffer discarded, COM written to lane 0, lane_idx = 1, align_evt pulses next cycle, realign_cnt increments.
  - COM with lane_idx == 0: normal write, no align_evt.
  - Normal: symbol and K flag written to lane lane_idx, then lane_idx increments.
- Word completion:
  - When the write targets lane NUM_LANES-1, lane_idx wraps to 0.
  - On the next edge: data_out/k_out load the full word, valid_out = 1 for exactly one cycle, lane0_sym is updated.
  - Latency: last symbol accepted at edge N → valid_out high after edge N+1.
- data_out, k_out and lane0_sym hold their values between words.
- valid_in = 0: no state change; valid_out still fires if a completion is pending.
- A COM realign arriving in the same cycle as a pending completion: the completed word is still emitted, and the COM starts the next word.
- Gaps in valid_in do not reset lane_idx.
- Counters saturate at all-ones and never wrap.
- Only reset clears the counters; reset mid-word discards the partial word.
- NUM_LANES must be a power of two or not; lane_idx is a width-$clog2(NUM_LANES) counter with an explicit wrap compare.

Optional Feature:
- Macro LANE_DEMUX_SYM_CHECK_EN.
- Defined:
  - An accepted K symbol outside the code list sets sym_err for one cycle (aligned with the buffer write + 1) and increments err_cnt.
  - The symbol is still stored; lane0_sym reports 7 if it lands in lane 0.
- Undefined:
  - sym_err and err_cnt are tied to 0.
  - Unknown K symbols are classified as 7 without flagging.

Decomposition:
- Package phy_sym_pkg holds:
  - the six symbol code constants;
  - the 3-bit sym_class enum and its localparams;
  - a function classify(k, byte) returning sym_class.
- One sub-module, lane_demux_sym_class: a combinational classifier instanced on lane 0 of the buffer. The checker reuses the package function.

Test Plan:
- Reset, NUM_LANES = 4, feed D 01,02,03,04 (k = 0) back-to-back → one valid_out pulse, data_out = 32'h04030201, k_out = 0, lane0_sym = 0.
- Feed 01, SKP(K), 02, 03, 04 → SKP ignored; data_out = 32'h04030201, single pulse.
- Feed 11, 22, COM(K), 33, 44, 55 → align_evt pulse, realign_cnt = 1, data_out = 32'h554433BC, k_out = 4'b0001, lane0_sym = 1.
- Feed STP(K), AA, BB, END(K) with valid_in toggling 1/0 → word = 32'hFDBBAAFB, k_out = 4'b1001, lane0_sym = 2, lane_idx preserved across gaps.
- With LANE_DEMUX_SYM_CHECK_EN, feed K 8'h3C then 3 data → sym_err pulse, err_cnt = 1, lane0_sym = 7; 300 such symbols → err_cnt = 255.
- Assert reset after 2 of 4 symbols, then feed 4 new symbols → only the new word is emitted, and all counters are 0 before it.

Source files
------------

// File: rtl/phy_sym_pkg.sv
`default_nettype none
// ============================================================================
// Module      : phy_sym_pkg
// Description : Shared symbol-level definitions for the lane demux data path:
//               K-symbol codes, the 3-bit symbol class encoding and a
//               classifier function used by both the lane-0 classifier and
//               the optional unknown-K checker.
// Revision    : 1.0 - initial release
// ============================================================================
package phy_sym_pkg;

    // K-symbol codes
    localparam logic [7:0] c_SYM_COM = 8'hBC;
    localparam logic [7:0] c_SYM_SKP = 8'h1C;
    localparam logic [7:0] c_SYM_STP = 8'hFB;
    localparam logic [7:0] c_SYM_SDP = 8'h5C;
    localparam logic [7:0] c_SYM_END = 8'hFD;
    localparam logic [7:0] c_SYM_IDL = 8'h7C;

    localparam int c_SYM_CLASS_W = 3;

    // SKP has its own class so the classifier is total over the code list;
    // a SKP never reaches the assembly buffer, so lane0_sym never reports 6.
    typedef enum logic [c_SYM_CLASS_W-1:0] {
        SYM_DATA      = 3'd0,
        SYM_COM       = 3'd1,
        SYM_STP       = 3'd2,
        SYM_SDP       = 3'd3,
        SYM_END       = 3'd4,
        SYM_IDL       = 3'd5,
        SYM_SKP       = 3'd6,
        SYM_UNKNOWN_K = 3'd7
    } sym_class_t;

    function automatic sym_class_t classify(input logic k, input logic [7:0] sym);
        sym_class_t cls;
        cls = SYM_DATA;
        if (k) begin
            case (sym)
                c_SYM_COM: cls = SYM_COM;
                c_SYM_SKP: cls = SYM_SKP;
                c_SYM_STP: cls = SYM_STP;
                c_SYM_SDP: cls = SYM_SDP;
                c_SYM_END: cls = SYM_END;
                c_SYM_IDL: cls = SYM_IDL;
                default:   cls = SYM_UNKNOWN_K;
            endcase
        end
        return cls;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lane_demux_sym_class.sv
`default_nettype none
// ============================================================================
// Module      : lane_demux_sym_class
// Description : Combinational symbol classifier (instanced on buffer lane 0).
// Ports       : i_k     - K flag of the symbol
//               i_data  - symbol byte
//               o_class - symbol class (phy_sym_pkg::sym_class_t)
// Revision    : 1.0 - initial release
// ============================================================================
module lane_demux_sym_class
    import phy_sym_pkg::*;
(
    input  logic       i_k,
    input  logic [7:0] i_data,
    output sym_class_t o_class
);

    assign o_class = classify(i_k, i_data);

endmodule
`default_nettype wire

// File: rtl/lane_demux_n.sv
`default_nettype none
// ============================================================================
// Module      : lane_demux_n
// Description : Byte-to-word lane demultiplexer. Stripes accepted symbols into
//               NUM_LANES byte lanes and emits one word per NUM_LANES accepted
//               symbols. SKP is dropped, a K-COM realigns to lane 0, and the
//               lane-0 symbol of each emitted word is classified.
// Ports       : clk, reset (async, active-high)
//               data_in/k_in/valid_in  - symbol input
//               data_out/k_out/valid_out - assembled word, one-cycle strobe
//               lane0_sym   - class of lane 0 of the emitted word
//               align_evt   - pulse when a COM discards a partial word
//               realign_cnt - saturating count of align_evt
//               sym_err     - unknown-K pulse (checker build only)
//               err_cnt     - saturating count of sym_err
// Options     : LANE_DEMUX_SYM_CHECK_EN - enables the unknown-K checker;
//               when undefined sym_err and err_cnt are tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module lane_demux_n
    import phy_sym_pkg::*;
#(
    parameter int NUM_LANES    = 4,
    parameter bit ALIGN_ON_COM = 1'b1,
    parameter int CNT_W        = 8
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             data_in,
    input  logic                   k_in,
    input  logic                   valid_in,
    output logic [8*NUM_LANES-1:0] data_out,
    output logic [NUM_LANES-1:0]   k_out,
    output logic                   valid_out,
    output logic [2:0]             lane0_sym,
    output logic                   align_evt,
    output logic [CNT_W-1:0]       realign_cnt,
    output logic                   sym_err,
    output logic [CNT_W-1:0]       err_cnt
);

    localparam int                 c_IDX_W    = $clog2(NUM_LANES);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_LANES - 1);

    logic [c_IDX_W-1:0]     r_lane_idx;
    logic                   r_pending;      // word completed at the previous edge
    logic [8*NUM_LANES-1:0] w_buf_data;
    logic [NUM_LANES-1:0]   w_buf_k;
    sym_class_t             w_lane0_class;

    logic w_is_skp;
    logic w_accept;
    logic w_realign;
    logic w_write;
    logic w_last;

    assign w_is_skp  = k_in && (data_in == c_SYM_SKP);
    assign w_accept  = valid_in && !w_is_skp;
    // A COM only realigns when it would land mid-word; at lane 0 it is a plain write.
    assign w_realign = w_accept && ALIGN_ON_COM && k_in && (data_in == c_SYM_COM)
                       && (r_lane_idx != '0);
    assign w_write   = w_accept && !w_realign;
    // Explicit compare so non-power-of-two lane counts wrap correctly.
    assign w_last    = (r_lane_idx == c_LAST_IDX);

    // ------------------------------------------------------------------
    // Lane index and completion tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lane_idx <= '0;
            r_pending  <= 1'b0;
        end else begin
            r_pending <= w_write && w_last;
            if (w_realign) begin
                r_lane_idx <= c_IDX_W'(1);
            end else if (w_write) begin
                r_lane_idx <= w_last ? '0 : (r_lane_idx + c_IDX_W'(1));
            end
        end
    end

    // ------------------------------------------------------------------
    // Assembly buffer, one byte + K flag per lane
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [7:0] r_data;
        logic       r_k;
        logic       w_lane_hit;

        assign w_lane_hit = w_write && (r_lane_idx == c_IDX_W'(i));

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_data <= '0;
                r_k    <= 1'b0;
            end else if (w_realign) begin
                // Drop the partial word; the COM opens the new one in lane 0.
                r_data <= (i == 0) ? c_SYM_COM : 8'h00;
                r_k    <= (i == 0);
            end else if (w_lane_hit) begin
                r_data <= data_in;
                r_k    <= k_in;
            end
        end

        assign w_buf_data[8*i +: 8] = r_data;
        assign w_buf_k[i]           = r_k;
    end

    lane_demux_sym_class u_lane0_class (
        .i_k     (w_buf_k[0]),
        .i_data  (w_buf_data[7:0]),
        .o_class (w_lane0_class)
    );

    // ------------------------------------------------------------------
    // Output word register and realign bookkeeping. The buffer is sampled
    // one edge after the last write, so a new symbol written into lane 0 on
    // the same edge does not disturb the word being emitted.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out    <= '0;
            k_out       <= '0;
            valid_out   <= 1'b0;
            lane0_sym   <= '0;
            align_evt   <= 1'b0;
            realign_cnt <= '0;
        end else begin
            valid_out <= r_pending;
            align_evt <= w_realign;
            if (r_pending) begin
                data_out  <= w_buf_data;
                k_out     <= w_buf_k;
                lane0_sym <= w_lane0_class;
            end
            if (w_realign && (realign_cnt != {CNT_W{1'b1}})) begin
                realign_cnt <= realign_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Unknown-K checker
    // ------------------------------------------------------------------
`ifdef LANE_DEMUX_SYM_CHECK_EN
    logic w_unknown;

    assign w_unknown = w_accept && k_in && (classify(k_in, data_in) == SYM_UNKNOWN_K);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sym_err <= 1'b0;
            err_cnt <= '0;
        end else begin
            sym_err <= w_unknown;
            if (w_unknown && (err_cnt != {CNT_W{1'b1}})) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end
`else
    assign sym_err = 1'b0;
    assign err_cnt = '0;
`endif

endmodule
`default_nettype wire
